frequency_generator: RTL and testbench



---
 rtl/frequency_generator.sv | 104 ++++++++++
 tb/tb_frequency_generator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/frequency_generator.sv
// Square-wave source: emits 10*tens+units rising edges per UPDATE_PERIOD-clock
// window, spreading them evenly with a DDA accumulator after a serial BCD conversion.
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int BITS          = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       load,
  output logic       signal,
  output logic       window_start,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, RUN} state_t;

  localparam logic [BITS-1:0] LAST_SAMPLE = BITS'(UPDATE_PERIOD - 1);
  localparam logic [BITS:0]   PERIOD      = (BITS+1)'(UPDATE_PERIOD);

  state_t          state_q;
  logic [3:0]      tens_cnt_q;
  logic [6:0]      rate_q;
  logic [BITS-1:0] acc_q;
  logic [BITS-1:0] sample_q;
  logic            signal_q;
  logic            window_start_q;
  logic            busy_q;

  logic [BITS:0]   nxt_d;
  logic [BITS:0]   diff_d;
  logic            wrap_d;
  logic [BITS-1:0] acc_d;
  logic [BITS-1:0] sample_d;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // The sum is one bit wider than the accumulator so the compare never sees a wrapped value.
  always_comb begin
    nxt_d    = {1'b0, acc_q} + {{(BITS-7){1'b0}}, rate_q, 1'b0};
    diff_d   = nxt_d - PERIOD;
    wrap_d   = (nxt_d >= PERIOD);
    acc_d    = wrap_d ? diff_d[BITS-1:0] : nxt_d[BITS-1:0];
    sample_d = (sample_q == LAST_SAMPLE) ? '0 : sample_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      tens_cnt_q     <= '0;
      rate_q         <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      signal_q       <= 1'b0;
      window_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else if (load) begin
      // A new request abandons whatever was in flight, including a partial window.
      state_q        <= CONVERT;
      tens_cnt_q     <= clamp_digit(tens);
      rate_q         <= {3'b000, clamp_digit(units)};
      acc_q          <= '0;
      sample_q       <= '0;
      signal_q       <= 1'b0;
      window_start_q <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          signal_q       <= 1'b0;
          window_start_q <= 1'b0;
        end
        CONVERT: begin
          window_start_q <= 1'b0;
          if (tens_cnt_q != 4'd0) begin
            rate_q     <= rate_q + 7'd10;
            tens_cnt_q <= tens_cnt_q - 4'd1;
          end else begin
            state_q  <= RUN;
            acc_q    <= '0;
            sample_q <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        RUN: begin
          window_start_q <= (sample_q == '0);
          sample_q       <= sample_d;
          acc_q          <= acc_d;
          if (wrap_d) signal_q <= ~signal_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign signal       = signal_q;
  assign window_start = window_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: directed and random rate requests checked
// against an edge-count / timing model of the generated waveform.
module tb_frequency_generator;

  localparam int P = 1200;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tens;
  logic [3:0] units;
  logic       load;
  logic       signal;
  logic       window_start;
  logic       busy;

  int checks = 0;
  int errors = 0;

  frequency_generator #(.UPDATE_PERIOD(P), .BITS(12)) dut (
    .clk(clk), .reset(reset), .tens(tens), .units(units), .load(load),
    .signal(signal), .window_start(window_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one cycle; returns right after the sampling edge.
  task automatic do_load(input int t, input int u);
    tens  = 4'(t);
    units = 4'(u);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("sig_after_load", int'(signal), 0);
    check("ws_after_load", int'(window_start), 0);
  endtask

  // Measures busy length and latency to the first window_start after a load.
  task automatic wait_start(input int t);
    int k = 0;
    int bcnt = 0;
    while (!window_start && k < 100) begin
      if (busy) bcnt++;
      tick();
      k++;
    end
    check("busy_len", bcnt, clampd(t) + 1);
    check("ws_latency", k, clampd(t) + 2);
  endtask

  // Entered with window_start high; observes nwin whole windows.
  task automatic run_windows(input int nwin, input int n);
    for (int w = 0; w < nwin; w++) begin
      int edges = 0, last = -1, mins = P, maxs = 0, stray_ws = 0;
      logic prev;
      check("ws_entry", int'(window_start), 1);
      check("sig_at_ws", int'(signal), 0);
      prev = signal;
      for (int c = 1; c <= P; c++) begin
        tick();
        if (c < P && window_start) stray_ws++;
        if (c < P && signal && !prev) begin
          edges++;
          if (last >= 0) begin
            if (c - last < mins) mins = c - last;
            if (c - last > maxs) maxs = c - last;
          end
          last = c;
        end
        prev = signal;
      end
      check("edges_per_window", edges, n);
      check("stray_window_start", stray_ws, 0);
      if (n >= 2) begin
        check("min_spacing_ok", int'(n * mins >= P - n), 1);
        check("max_spacing_ok", int'(n * maxs <= P + n), 1);
      end
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1; load = 1'b0; tens = '0; units = '0;
    repeat (3) tick();
    check("rst_signal", int'(signal), 0);
    check("rst_ws", int'(window_start), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Idle without load: everything stays low.
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (signal || window_start || busy) bad++;
    end
    check("idle_quiet", bad, 0);

    do_load(4, 2); wait_start(4); run_windows(2, 42);

    do_load(0, 0); wait_start(0); run_windows(3, 0);
    do_load(9, 9); wait_start(9); run_windows(1, 99);

    do_load(15, 12); wait_start(15); run_windows(1, 99);

    // Interrupt a running window at sample 600.
    do_load(4, 2); wait_start(4);
    repeat (600) tick();
    do_load(1, 7);
    check("busy_after_reload", int'(busy), 1);
    wait_start(1); run_windows(2, 17);

    // Reset mid-window clears everything and stays cleared until a new load.
    repeat (300) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_signal", int'(signal), 0);
    check("midrst_ws", int'(window_start), 0);
    check("midrst_busy", int'(busy), 0);
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (signal || window_start || busy) bad++;
    end
    check("post_reset_quiet", bad, 0);

    // Load coinciding with reset is ignored.
    tens = 4'd3; units = 4'd7; load = 1'b1; reset = 1'b1;
    tick();
    load = 1'b0; reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (signal || window_start || busy) bad++;
    end
    check("reset_beats_load", bad, 0);

    // Loopback-style measurement at 37 edges per window.
    do_load(3, 7); wait_start(3); run_windows(2, 37);

    // Random digit requests, including out-of-range digits.
    for (int r = 0; r < 5; r++) begin
      int t, u;
      t = int'($urandom_range(0, 15));
      u = int'($urandom_range(0, 15));
      do_load(t, u); wait_start(t);
      run_windows(1, 10 * clampd(t) + clampd(u));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
